// File: rtl/integer_division_pkg.sv
// Constants shared by the divide/modulus stage and the recompose stage:
// divisor, its width, FSM encoding and accumulator sizing.
package integer_division_pkg;

   localparam int unsigned DIVISOR   = 1234101;
   localparam int unsigned DIV_BITS  = 21;
   localparam int unsigned DEF_WIDTH = 32;

   // The extra bit absorbs the carry from adding r, so the accumulator can never wrap
   localparam int unsigned ACC_WIDTH = DEF_WIDTH + DIV_BITS + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int unsigned acc_width(input int unsigned w);
      return w + DIV_BITS + 1;
   endfunction

endpackage

// File: rtl/integer_recompose_serial_shift_add_step.sv
// One partial-product step of the serial multiplier:
// o_acc_next = i_acc + (i_bit ? DIVISOR << i_cnt : 0).
module shift_add_step
   import integer_division_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_WIDTH,
   parameter int unsigned CNT_W = 5
) (
   input  logic [ACC_W-1:0] i_acc,
   input  logic             i_bit,
   input  logic [CNT_W-1:0] i_cnt,
   output logic [ACC_W-1:0] o_acc_next
);

   localparam logic [ACC_W-1:0] DIV_EXT = ACC_W'(DIVISOR);

   logic [ACC_W-1:0] w_addend;

   always_comb begin
      w_addend   = i_bit ? (DIV_EXT << i_cnt) : '0;
      o_acc_next = i_acc + w_addend;
   end

endmodule

// File: rtl/integer_recompose_serial.sv
// Serial rebuild of a = q*DIVISOR + r, one quotient bit per cycle, with valid/ready on both sides.
// Optional macro RANGE_CHECK_EN adds the r >= DIVISOR flag (rng_err); otherwise rng_err is tied 0.
module integer_recompose_serial
   import integer_division_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a,
   output logic             ovf,
   output logic             rng_err
);

   localparam int unsigned ACC_W    = acc_width(WIDTH);
   localparam int unsigned CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_q_sh;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic             r_ovf;
   logic [ACC_W-1:0] w_acc_next;
   logic             w_accept;
   logic             w_finish;

   shift_add_step #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_step (
      .i_acc      (r_acc),
      .i_bit      (r_q_sh[0]),
      .i_cnt      (r_cnt),
      .o_acc_next (w_acc_next)
   );

   assign w_accept  = (r_state == ST_IDLE) && in_valid;
   assign w_finish  = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign a         = r_a;
   assign ovf       = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_q_sh  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_q_sh  <= q;
                  r_acc   <= ACC_W'(r);
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_acc  <= w_acc_next;
               r_q_sh <= r_q_sh >> 1;
               r_cnt  <= r_cnt + 1'b1;
               // Fixed WIDTH-cycle latency: no early exit when the remaining quotient bits are zero
               if (w_finish) begin
                  r_state <= ST_DONE;
                  r_a     <= w_acc_next[WIDTH-1:0];
                  r_ovf   <= |w_acc_next[ACC_W-1:WIDTH];
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef RANGE_CHECK_EN
   logic r_rng_pend;
   logic r_rng_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rng_pend <= 1'b0;
         r_rng_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rng_pend <= (r >= WIDTH'(DIVISOR));
         end
         if (w_finish) begin
            r_rng_err <= r_rng_pend;
         end
      end
   end

   assign rng_err = r_rng_err;
`else
   assign rng_err = 1'b0;
`endif

endmodule

// File: tb/tb_integer_recompose_serial.sv
// Directed bench for integer_recompose_serial: latency, results, ovf, back-pressure and mid-run reset.
// Honours RANGE_CHECK_EN so the rng_err expectation follows the build.
module tb_integer_recompose_serial;

   localparam int W = 32;
`ifdef RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] a;
   logic         ovf;
   logic         rng_err;

   int n_tests = 0;
   int n_fail  = 0;

   integer_recompose_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a         (a),
      .ovf       (ovf),
      .rng_err   (rng_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one pair, check latency, result and handshake release
   task automatic run_op(input string tag, input logic [W-1:0] qv, input logic [W-1:0] rv,
                         input logic [W-1:0] ea, input logic eo, input logic er);
      @(negedge clk);
      q = qv; r = rv; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, ".busy"}, 64'(in_ready), 64'd0);
      repeat (W - 1) @(posedge clk);
      #1;
      check({tag, ".early"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".a"}, 64'(a), 64'(ea));
      check({tag, ".ovf"}, 64'(ovf), 64'(eo));
      check({tag, ".rng"}, 64'(rng_err), 64'(er));
      $display("[TB] %s q=%0d r=%0d -> a=%0d ovf=%0d rng_err=%0d", tag, qv, rv, a, ovf, rng_err);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".drop"}, 64'(out_valid), 64'd0);
      check({tag, ".ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q = '0; r = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.in_ready", 64'(in_ready), 64'd1);
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.a", 64'(a), 64'd0);
      check("reset.ovf", 64'(ovf), 64'd0);
      check("reset.rng", 64'(rng_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("q3r5",      32'd3,    32'd5,       32'd3702308,    1'b0, 1'b0);
      run_op("q0r0",      32'd0,    32'd0,       32'd0,          1'b0, 1'b0);
      run_op("q0r77",     32'd0,    32'd77,      32'd77,         1'b0, 1'b0);
      run_op("q3480r0",   32'd3480, 32'd0,       32'd4294671480, 1'b0, 1'b0);
      run_op("q3480rmax", 32'd3480, 32'd1234100, 32'd938284,     1'b1, 1'b0);
      run_op("q2rdiv",    32'd2,    32'd1234101, 32'd3702303,    1'b0, RC);
      run_op("qmaxrmax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4293733194, 1'b1, RC);

      // Back-pressure: result must hold while out_ready is low; new inputs are ignored
      @(negedge clk);
      q = 32'd1; r = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      q = 32'd9; r = 32'd9;
      repeat (W) @(posedge clk);
      #1;
      check("bp.valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp.hold_a", 64'(a), 64'd1234102);
         check("bp.hold_valid", 64'(out_valid), 64'd1);
         check("bp.in_ready", 64'(in_ready), 64'd0);
      end
      $display("[TB] bp q=1 r=1 -> a=%0d held 5 cycles", a);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp.release", 64'(out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bp.no_queue", 64'(in_ready), 64'd1);

      // Reset at RUN cycle 10 drops the operation
      @(negedge clk);
      q = 32'd5; r = 32'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst.in_ready", 64'(in_ready), 64'd1);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.a", 64'(a), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
         end
         check("rst.no_output", 64'(seen), 64'd0);
      end
      $display("[TB] reset mid-run dropped operation");
      run_op("after_rst", 32'd3, 32'd5, 32'd3702308, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
